wb_multiport_memory: RTL
========================

Name: wb_multiport_memory

Overview:
- Parametrised successor to the single-port simulation/FPGA memory used behind processorci_top.
- Serves NUM_PORTS independent Wishbone-classic slave channels from one shared word array. Typical use: instruction bus, data bus and a debug/DMA port.
- Adds byte selects, configurable wait states, round-robin arbitration, out-of-range error response and cycle-abort handling.

Parameters:
- NUM_PORTS, 2, number of slave channels (1..8).
- DATA_WIDTH, 32, word width in bits (32 or 64).
- ADDR_WIDTH, 32, byte-address width per channel.
- MEMORY_SIZE, 4096, size in bytes; power of two, multiple of DATA_WIDTH/8.
- WAIT_STATES, 0, extra cycles between grant and ack (0..15).
- MEMORY_FILE, "", hex file loaded at elaboration; empty string means contents are zero.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- cyc_i  in  NUM_PORTS  per-channel bus cycle.
- stb_i  in  NUM_PORTS  per-channel strobe.
- we_i  in  NUM_PORTS  per-channel write enable.
- sel_i  in  NUM_PORTS*DATA_WIDTH/8  byte selects; channel p occupies slice p.
- addr_i  in  NUM_PORTS*ADDR_WIDTH  byte addresses, sliced per channel.
- data_i  in  NUM_PORTS*DATA_WIDTH  write data, sliced per channel.
- data_o  out  NUM_PORTS*DATA_WIDTH  read data, sliced per channel.
- ack_o  out  NUM_PORTS  one-cycle completion pulse.
- err_o  out  NUM_PORTS  one-cycle error pulse (out-of-range access).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all ack_o and err_o are 0; all data_o are 0.
  - Round-robin pointer resets to NUM_PORTS-1, so port 0 wins the first contest.
  - Memory array contents are not reset.
- Request: channel p requests when cyc_i[p] & stb_i[p] are both high.
- Word index: addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low address bits are ignored.
- In range: addr < MEMORY_SIZE.
- FSM IDLE:
  - Scan requesters starting at pointer+1, wrapping modulo NUM_PORTS.
  - First requester found is granted. Latch port, we, sel, addr and data; set pointer to the granted port.
  - If WAIT_STATES=0 go to RESP, else go to WAIT with counter=WAIT_STATES-1.
  - With no requesters, stay in IDLE.
- FSM WAIT:
  - Decrement counter each cycle; go to RESP when the counter reaches 0.
  - If cyc_i[granted] drops, abort to IDLE: no write, no ack, no err.
- FSM RESP: single cycle; always goes to IDLE the next cycle.
  - In range: ack_o[granted]=1 for this cycle.
  - Write: bytes with sel=1 are updated at the edge entering RESP. Unselected bytes are unchanged.
  - Read: data_o slice is loaded with the full word at the same edge.
  - Out of range: err_o[granted]=1, no write, data_o slice loaded with 0.
  - An abort in the cycle before RESP is still detected; WAIT checks cyc at every edge.
- Latency: grant edge is N; ack/err is high during cycle N+1+WAIT_STATES.
  - Minimum spacing is 2 cycles per access (grant, RESP), +WAIT_STATES.
  - The RESP→IDLE cycle guarantees a compliant master has dropped stb before it is re-sampled.
- data_o[p] holds the last read value of port p until the next read completes on p. Writes do not alter data_o.
- Ungranted requesters wait; only one transaction is in flight at a time.
- ack_o and err_o are mutually exclusive and never asserted on an ungranted port.
- Read-after-write from another port sees the new data: accesses are serialised.
- Asserting rst mid-transaction drops ack/err immediately. A write not yet committed is lost.

Test Plan:
- Read: MEMORY_FILE word 0 = 0xDEADBEEF, port 0 reads addr 0x0, WAIT_STATES=0 -> ack_o[0] high 2nd cycle after stb (grant edge +1), data_o[0]=0xDEADBEEF.
- Byte write: port 1 writes 0x11223344 with sel=4'b0101 to addr 0x10 holding 0xAABBCCDD, then reads it back -> read returns 0xAA22CC44.
- Arbitration: ports 0 and 1 both request continuously after reset -> grants alternate 0,1,0,1; each ack arrives exactly 2 cycles apart per grant.
- Wait states: WAIT_STATES=3, single read -> ack 4 cycles after grant edge; ack_o is high for exactly one cycle.
- Error: read addr 0x1000 with MEMORY_SIZE=4096 -> err_o pulses and ack_o stays 0; data_o=0. A write to 0x1000 leaves all words unchanged.
- Abort/reset: WAIT_STATES=3, write 0x5A5A5A5A to 0x20, drop cyc after 1 wait cycle -> no ack and word unchanged. Repeat with rst pulsed in WAIT -> outputs 0, word unchanged, next request granted to port 0.

Source files
------------

// File: rtl/wb_multiport_memory.sv
// rtl/wb_multiport_memory.sv - shared word memory serving several Wishbone-classic slave channels
module wb_multiport_memory #(
  parameter int    NUM_PORTS   = 2,
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 32,
  parameter int    MEMORY_SIZE = 4096,
  parameter int    WAIT_STATES = 0,
  parameter string MEMORY_FILE = ""
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              cyc_i,
  input  logic [NUM_PORTS-1:0]              stb_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] sel_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   data_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   data_o,
  output logic [NUM_PORTS-1:0]              ack_o,
  output logic [NUM_PORTS-1:0]              err_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int DEPTH = MEMORY_SIZE / BYTES;
  localparam int IW    = $clog2(DEPTH);
  localparam int SIZEW = $clog2(MEMORY_SIZE);
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW    = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           gnt;
  logic                    l_we;
  logic [BYTES-1:0]        l_sel;
  logic [ADDR_WIDTH-1:0]   l_addr;
  logic [DATA_WIDTH-1:0]   l_data;
  logic [CW-1:0]           cnt;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [NUM_PORTS-1:0]    req;
  logic                    win_found;
  logic [PW-1:0]           win;

  logic                    fire;
  logic [PW-1:0]           c_port;
  logic                    c_we;
  logic [BYTES-1:0]        c_sel;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_data;
  logic                    in_range;
  logic [IW-1:0]           c_idx;

  assign req = cyc_i & stb_i;

  // Round-robin scan: first requester after the last granted port wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win       = ptr;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = PW'(idx);
      end
    end
  end

  // Select the transaction that completes at this edge: the live winner when
  // there are no wait states, otherwise the latched request at the end of WAIT.
  always_comb begin
    c_port = gnt;
    c_we   = l_we;
    c_sel  = l_sel;
    c_addr = l_addr;
    c_data = l_data;
    fire   = 1'b0;
    if (state == IDLE) begin
      c_port = win;
      c_we   = we_i[win];
      c_sel  = sel_i[int'(win)*BYTES +: BYTES];
      c_addr = addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      c_data = data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      fire   = win_found && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      fire   = cyc_i[gnt] && (cnt == '0);
    end
  end

  assign in_range = (c_addr >> SIZEW) == '0;
  assign c_idx    = c_addr[OFF +: IW];

  // Byte-masked commit of an in-range write on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!rst && fire && c_we && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (c_sel[b]) mem[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
      end
    end
  end

  // Arbitration FSM with registered ack/err pulses and per-port read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= PW'(NUM_PORTS - 1);
      gnt    <= '0;
      l_we   <= 1'b0;
      l_sel  <= '0;
      l_addr <= '0;
      l_data <= '0;
      cnt    <= '0;
      ack_o  <= '0;
      err_o  <= '0;
      data_o <= '0;
    end else begin
      ack_o <= '0;
      err_o <= '0;
      if (fire) begin
        ack_o[c_port] <= in_range;
        err_o[c_port] <= !in_range;
        if (!in_range) begin
          data_o[int'(c_port)*DATA_WIDTH +: DATA_WIDTH] <= '0;
        end else if (!c_we) begin
          data_o[int'(c_port)*DATA_WIDTH +: DATA_WIDTH] <= mem[c_idx];
        end
      end
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt    <= win;
            ptr    <= win;
            l_we   <= c_we;
            l_sel  <= c_sel;
            l_addr <= c_addr;
            l_data <= c_data;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!cyc_i[gnt]) state <= IDLE;
          else if (cnt == '0) state <= RESP;
          else cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
